// File: rtl/ps2_pkg.sv
// Shared PS/2 host-transmit definitions: FSM encoding, timing defaults, command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        RTS       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5,
        FIN       = 3'd6,
        FAIL      = 3'd7
    } ps2_state_e;

    // Defaults for a 25 MHz system clock
    localparam int unsigned INHIBIT_CYC_DEF = 2500;    // 100 us
    localparam int unsigned TIMEOUT_CYC_DEF = 375000;  // 15 ms
    localparam int unsigned CNT_W_DEF       = 19;

    localparam int unsigned IDX_W    = 4;
    localparam int unsigned PAR_IDX  = 8;
    localparam int unsigned STOP_IDX = 9;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // Line level for frame position idx: data bits, odd parity, then stop (released)
    function automatic logic tx_bit(input logic [7:0] data, input logic par,
                                    input logic [IDX_W-1:0] idx);
        logic b;
        if (idx < IDX_W'(PAR_IDX)) begin
            b = data[idx[2:0]];
        end else if (idx == IDX_W'(PAR_IDX)) begin
            b = par;
        end else begin
            b = 1'b1;
        end
        return b;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a PS/2 pad with falling-edge detect; advances only on enable.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic pad_i,
    output logic q0_o,
    output logic q1_o,
    output logic fe_c
);

    logic q0_q, q1_q;

    // Synchronizer chain; idle bus level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0_q <= 1'b1;
            q1_q <= 1'b1;
        end else if (enable) begin
            q0_q <= pad_i;
            q1_q <= q0_q;
        end
    end

    assign q0_o = q0_q;
    assign q1_o = q1_q;
    assign fe_c = q1_q & ~q0_q;

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host transmit controller: inhibit, request-to-send, 10 host bits, device ACK.
module ps2_host_ctrl
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYC = INHIBIT_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       wr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       PS2C,
    input  logic       PS2D,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       rx_rst
);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    ps2_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       data_q, data_d;
    logic             par_q, par_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             c_oe_q, c_oe_d, d_oe_q, d_oe_d;
    logic             rx_rst_q, rx_rst_d;

    logic c_q0, c_q1, c_fe, d_q0, d_s, d_fe, timeout;
    logic unused_sync;

    ps2_sync_edge u_sync_c (
        .clk    (clk),
        .rst_n  (rst),
        .enable (enable),
        .pad_i  (PS2C),
        .q0_o   (c_q0),
        .q1_o   (c_q1),
        .fe_c   (c_fe)
    );

    ps2_sync_edge u_sync_d (
        .clk    (clk),
        .rst_n  (rst),
        .enable (enable),
        .pad_i  (PS2D),
        .q0_o   (d_q0),
        .q1_o   (d_s),
        .fe_c   (d_fe)
    );

    assign unused_sync = ^{c_q1, d_q0, d_fe};

    // Saturating counter: never wraps, FSM exits on the terminal value
    assign timeout = (cnt_q == TO_LAST);
    assign cnt_inc = timeout ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        idx_d   = idx_q;
        data_d  = data_q;
        par_d   = par_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (wr) begin
                    data_d  = wdata;
                    par_d   = ~^wdata;
                    err_d   = 1'b0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d   = '0;
                    state_d = RTS;
                end
            end
            RTS: begin
                if (c_fe) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = SEND;
                end else if (timeout) begin
                    state_d = FAIL;
                end
            end
            SEND: begin
                if (c_fe) begin
                    cnt_d = '0;
                    if (idx_q == IDX_W'(STOP_IDX)) begin
                        state_d = ACK;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (timeout) begin
                    state_d = FAIL;
                end
            end
            ACK: begin
                if (c_fe) begin
                    cnt_d   = '0;
                    state_d = d_s ? FAIL : WAIT_IDLE;
                end else if (timeout) begin
                    state_d = FAIL;
                end
            end
            WAIT_IDLE: begin
                if (c_q0 && d_s) begin
                    state_d = FIN;
                end else if (timeout) begin
                    state_d = FAIL;
                end
            end
            FIN: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            FAIL: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        if (state_d == FAIL) begin
            err_d = 1'b1;
        end

        busy_d   = (state_d != IDLE);
        rx_rst_d = (state_d == IDLE);
        done_d   = (state_d == FIN) || (state_d == FAIL);
        c_oe_d   = (state_d == INHIBIT);
        d_oe_d   = (state_d == RTS) ||
                   ((state_d == SEND) && !tx_bit(data_d, par_d, idx_d));
    end

    // State, datapath and output registers, all gated by enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            par_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            c_oe_q   <= 1'b0;
            d_oe_q   <= 1'b0;
            rx_rst_q <= 1'b1;
        end else if (enable) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            par_q    <= par_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            c_oe_q   <= c_oe_d;
            d_oe_q   <= d_oe_d;
            rx_rst_q <= rx_rst_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign ps2c_oe = c_oe_q;
    assign ps2d_oe = d_oe_q;
    assign rx_rst  = rx_rst_q;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Directed bench for ps2_host_ctrl with an inline PS/2 device model on open-drain pads.
module tb_ps2_host_ctrl;
    import ps2_pkg::*;

    localparam int unsigned INH  = 100;
    localparam int unsigned TO   = 1000;
    localparam int unsigned HALF = 20;

    logic       clk = 1'b0;
    logic       rst, enable, wr;
    logic [7:0] wdata;
    logic       busy, done, err, ps2c_oe, ps2d_oe, rx_rst;
    logic       dev_c, dev_d;
    logic       PS2C, PS2D;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int rx_bad = 0;

    // Wired-AND open-drain pads
    assign PS2C = dev_c & ~ps2c_oe;
    assign PS2D = dev_d & ~ps2d_oe;

    always #5 clk = ~clk;

    ps2_host_ctrl #(
        .INHIBIT_CYC (INH),
        .TIMEOUT_CYC (TO),
        .CNT_W       (19)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .wr      (wr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .PS2C    (PS2C),
        .PS2D    (PS2D),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe),
        .rx_rst  (rx_rst)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle, sampled on the falling edge, with pulse/receiver-reset monitoring
    task automatic tick();
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1 && rx_rst !== 1'b0) rx_bad++;
    endtask

    task automatic start_cmd(input logic [7:0] cmd);
        wr = 1'b1;
        wdata = cmd;
        tick();
        wr = 1'b0;
    endtask

    // Full transfer from the device side; rst_k aborts with reset in the low phase of clock k
    task automatic dev_xfer(input logic [7:0] cmd, input bit give_ack, input int poke_k,
                            input int rst_k, output logic [7:0] cap,
                            output logic cap_par, output logic cap_stop);
        int inh;
        cap = '0;
        cap_par = 1'b0;
        cap_stop = 1'b0;
        done_cnt = 0;
        rx_bad = 0;
        start_cmd(cmd);
        inh = 0;
        while (ps2c_oe === 1'b1 && inh < 4 * INH) begin
            inh++;
            tick();
        end
        check("inhibit_len", inh, INH);
        check("rts_data_low", ps2d_oe, 1);
        check("rts_clk_rel", ps2c_oe, 0);
        repeat (10) tick();
        for (int k = 1; k <= 12; k++) begin
            dev_c = 1'b0;
            repeat (HALF) tick();
            if (k == rst_k) begin
                check("pre_rst_d_oe", ps2d_oe, 1);
                rst = 1'b0;
                #1;
                check("rst_async_outs", {busy, done, err, ps2c_oe, ps2d_oe, rx_rst}, 6'b000001);
                dev_c = 1'b1;
                dev_d = 1'b1;
                return;
            end
            if (k == poke_k) begin
                wr = 1'b1;
                wdata = 8'h00;
                tick();
                wr = 1'b0;
            end
            if (k <= 8) cap[k-1] = PS2D;
            else if (k == 9) cap_par = PS2D;
            else if (k == 10) cap_stop = PS2D;
            dev_c = 1'b1;
            if (k == 10 && give_ack) dev_d = 1'b0;
            repeat (HALF) tick();
        end
        dev_d = 1'b1;
        repeat (30) tick();
    endtask

    logic [7:0] cap;
    logic       cp, cs;
    int         rts;

    initial begin
        rst = 1'b0;
        enable = 1'b1;
        wr = 1'b0;
        wdata = '0;
        dev_c = 1'b1;
        dev_d = 1'b1;
        repeat (3) tick();
        check("reset_outs", {busy, done, err, ps2c_oe, ps2d_oe, rx_rst}, 6'b000001);
        rst = 1'b1;
        repeat (3) tick();

        // Strobe while disabled must not start a transfer
        enable = 1'b0;
        wr = 1'b1;
        wdata = CMD_ENABLE;
        repeat (5) tick();
        wr = 1'b0;
        check("disabled_busy", busy, 0);
        enable = 1'b1;
        repeat (2) tick();
        check("disabled_idle", {busy, ps2c_oe}, 2'b00);

        // 0xF4 with ACK
        dev_xfer(CMD_ENABLE, 1'b1, 0, 0, cap, cp, cs);
        check("f4_data", cap, 8'hF4);
        check("f4_par", cp, 0);
        check("f4_stop", cs, 1);
        check("f4_done_cnt", done_cnt, 1);
        check("f4_err_busy", {err, busy}, 2'b00);
        check("f4_rx_rst", rx_bad, 0);

        // 0xED then 0xFF back-to-back
        dev_xfer(CMD_SET_LEDS, 1'b1, 0, 0, cap, cp, cs);
        check("ed_data", cap, 8'hED);
        check("ed_par", cp, 1);
        check("ed_done_cnt", done_cnt, 1);
        check("ed_rx_rst", rx_bad, 0);
        check("between_rx_rst", rx_rst, 1);
        dev_xfer(CMD_RESET, 1'b1, 0, 0, cap, cp, cs);
        check("ff_data", cap, 8'hFF);
        check("ff_par", cp, 1);
        check("ff_stop", cs, 1);
        check("ff_rx_rst", rx_bad, 0);
        check("ff_err", err, 0);

        // Device never clocks after RTS
        start_cmd(CMD_ENABLE);
        while (ps2c_oe === 1'b1) tick();
        rts = 0;
        while (ps2d_oe === 1'b1 && rts < int'(TO) + 50) begin
            rts++;
            tick();
        end
        check("to_rts_len", rts, TO);
        check("to_done", done, 1);
        check("to_err", err, 1);
        check("to_oe", {ps2c_oe, ps2d_oe}, 2'b00);
        tick();
        check("to_done_pulse", {done, busy}, 2'b00);
        repeat (5) tick();

        // Withheld ACK, then a good transfer clears err
        dev_xfer(CMD_ENABLE, 1'b0, 0, 0, cap, cp, cs);
        check("nack_done_cnt", done_cnt, 1);
        check("nack_err", err, 1);
        check("nack_oe", {ps2c_oe, ps2d_oe, busy}, 3'b000);
        dev_xfer(CMD_ENABLE, 1'b1, 0, 0, cap, cp, cs);
        check("after_nack_err", err, 0);
        check("after_nack_data", cap, 8'hF4);

        // wr during SEND is ignored
        dev_xfer(CMD_RESET, 1'b1, 4, 0, cap, cp, cs);
        check("poke_data", cap, 8'hFF);
        check("poke_par", cp, 1);
        check("poke_done_cnt", done_cnt, 1);
        check("poke_busy", busy, 0);

        // Reset mid-SEND at idx 4, then a normal transfer
        dev_xfer(CMD_SET_LEDS, 1'b1, 0, 5, cap, cp, cs);
        #1;
        rst = 1'b1;
        repeat (5) tick();
        check("post_rst_idle", {busy, rx_rst}, 2'b01);
        dev_xfer(CMD_ENABLE, 1'b1, 0, 0, cap, cp, cs);
        check("post_rst_data", cap, 8'hF4);
        check("post_rst_done", done_cnt, 1);
        check("post_rst_err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound
    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
